serial_alu_ctrl: RTL and testbench
==================================

Name: serial_alu_ctrl

Overview:
- Bit-serial sequencer around one `alu1bit` instance: computes a WIDTH-bit AND/OR/ADD/SUB by driving the 1-bit ALU for one bit per clock, LSB first.
- Holds the inter-bit carry in a flop, assembles the result in a shift register, and reports completion with a done pulse.
- Sits between a simple start/busy/done requester and the existing 1-bit ALU datapath.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range >= 2.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; accepted only in IDLE
- op  input  2  operation: 00 AND, 01 OR, 10 ADD, 11 SUB (a - b)
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle completion pulse
- result  output  WIDTH  final result
- carry_out  output  1  ADD: carry out; SUB: 1 = no borrow; AND/OR: 0
- zero  output  1  result == 0

Behaviour:
- Reset (async, rst_n=0):
  - state = IDLE.
  - busy, done, carry_out and zero = 0; result = 0.
  - Bit counter = 0; carry flop = 0.
  - Takes effect immediately, including mid-RUN; the in-flight operation is discarded and no done pulse is produced.
- FSM:
  - IDLE -> RUN on start=1.
  - RUN -> DONE when bit counter == WIDTH-1.
  - DONE -> IDLE unconditionally.
- Start acceptance (IDLE, start=1): latch a, b and op. Initialise the bit counter to 0, the carry flop to 1 for SUB, and the carry flop to 0 otherwise.
  - Operand or op changes after acceptance have no effect.
  - start in RUN or DONE is ignored and not queued.
- alu1bit drive in RUN, bit i = counter:
  - a_bit = A[i].
  - b_bit = B[i] for AND/OR/ADD; ~B[i] for SUB.
  - cin = carry flop.
  - alu1bit op codes: 00 AND, 01 OR, 10 XOR, 11 full-add. Controller AND -> 00, OR -> 01, ADD and SUB -> 11.
  - alu1bit inputs outside RUN: all 0, op = 00.
- Per RUN cycle:
  - The result shift register shifts right with s entering the MSB.
  - Carry flop <= cout for ADD/SUB; it is held at 0 for AND/OR.
  - Counter increments.
- Latency: start sampled at edge N; done = 1 for exactly the cycle following edge N+WIDTH+1. busy = 1 from edge N+1 through the DONE cycle.
- At DONE entry:
  - carry_out <= carry flop for ADD/SUB, 0 for AND/OR.
  - zero <= (final result == 0).
- Output stability:
  - result, carry_out and zero hold their values from DONE until the next accepted start.
  - During RUN, result shows the partial shift contents and is not valid.
- Width rules: no extension; ADD/SUB wrap modulo 2^WIDTH.
- Counter: $clog2(WIDTH) bits, no wrap beyond WIDTH-1.
- Back-to-back operation: earliest next accept is the cycle after DONE, i.e. the IDLE cycle; throughput is one operation per WIDTH+2 cycles.

Optional Feature:
- OVERFLOW_EN defined:
  - Adds port overflow (output, 1).
  - Two's-complement signed overflow for ADD/SUB = carry into MSB XOR carry out of MSB, captured in the MSB RUN cycle.
  - Registered at DONE entry; 0 for AND/OR; reset 0; held like carry_out.
- OVERFLOW_EN undefined: port and logic absent; everything else identical.

Test Plan:
- ADD a=8'h0F, b=8'h01, start for 1 cycle -> done exactly WIDTH+1=9 cycles after accept edge. result=8'h10, carry_out=0, zero=0, busy high 9 cycles.
- ADD a=8'hFF, b=8'h01 -> result=8'h00, carry_out=1, zero=1. SUB a=8'h07, b=8'h05 -> result=8'h02, carry_out=1.
- SUB a=8'h05, b=8'h07 -> result=8'hFE, carry_out=0. AND 8'hF0,8'h3C -> 8'h30. OR 8'hF0,8'h0F -> 8'hFF, zero=0, carry_out=0.
- start re-asserted with new operands on every RUN/DONE cycle of an ADD 8'h01+8'h01 -> result=8'h02, one done pulse only. Next op accepted only after returning to IDLE.
- rst_n low for 1 cycle at bit 3 of an ADD -> busy=0, result=0, no done. A new ADD 8'h02+8'h03 after release completes normally with result 8'h05.
- OVERFLOW_EN: ADD 8'h7F+8'h01 -> result 8'h80, overflow=1. SUB 8'h80-8'h01 -> 8'h7F, overflow=1. ADD 8'h01+8'h01 -> overflow=0.

Source files
------------

// File: rtl/serial_alu_ctrl.sv
// Bit-serial AND/OR/ADD/SUB sequencer driving one 1-bit ALU, LSB first, one bit per clock.
// Define OVERFLOW_EN to add the signed-overflow output for ADD/SUB.

module alu1bit (
   input  logic       i_a,
   input  logic       i_b,
   input  logic       i_cin,
   input  logic [1:0] i_op,
   output logic       o_s,
   output logic       o_cout
);
   always_comb begin
      // NOTE: every combinational output gets a default first so no path infers a latch.
      o_s    = 1'b0;
      o_cout = 1'b0;
      unique case (i_op)
         2'b00: o_s = i_a & i_b;
         2'b01: o_s = i_a | i_b;
         2'b10: o_s = i_a ^ i_b;
         2'b11: begin
            o_s    = i_a ^ i_b ^ i_cin;
            o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));
         end
      endcase
   end
endmodule

module serial_alu_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             zero
`ifdef OVERFLOW_EN
   ,
   output logic             overflow
`endif
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_a, r_b, r_shift;
   logic [1:0]       r_op;
   logic [CW-1:0]    r_cnt;
   logic             r_carry, r_busy, r_done, r_carry_out, r_zero;
`ifdef OVERFLOW_EN
   logic             r_ovf_msb, r_overflow;
`endif

   logic       w_run, w_arith;
   logic       w_alu_a, w_alu_b, w_alu_cin, w_alu_s, w_alu_cout;
   logic [1:0] w_alu_op;

   assign w_run   = (r_state == ST_RUN);
   assign w_arith = r_op[1];

   // SUB is a + ~b + 1: invert B here, the +1 comes from the carry preset at accept.
   assign w_alu_a   = w_run & r_a[r_cnt];
   assign w_alu_b   = w_run & (r_b[r_cnt] ^ (r_op == 2'b11));
   assign w_alu_cin = w_run & r_carry;
   assign w_alu_op  = !w_run ? 2'b00 : (w_arith ? 2'b11 : r_op);

   alu1bit u_alu (
      .i_a    (w_alu_a),
      .i_b    (w_alu_b),
      .i_cin  (w_alu_cin),
      .i_op   (w_alu_op),
      .o_s    (w_alu_s),
      .o_cout (w_alu_cout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_a         <= '0;
         r_b         <= '0;
         r_op        <= 2'b00;
         r_cnt       <= '0;
         r_carry     <= 1'b0;
         r_shift     <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_carry_out <= 1'b0;
         r_zero      <= 1'b0;
`ifdef OVERFLOW_EN
         r_ovf_msb   <= 1'b0;
         r_overflow  <= 1'b0;
`endif
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
         unique case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_a     <= a;
                  r_b     <= b;
                  r_op    <= op;
                  r_cnt   <= '0;
                  r_carry <= (op == 2'b11);
                  r_state <= ST_RUN;
               end
            end
            ST_RUN: begin
               r_shift <= {w_alu_s, r_shift[WIDTH-1:1]};
               r_carry <= w_arith & w_alu_cout;
               if (r_cnt == LAST) begin
                  r_state   <= ST_DONE;
`ifdef OVERFLOW_EN
                  r_ovf_msb <= w_alu_cin ^ w_alu_cout;
`endif
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            ST_DONE: begin
               r_carry_out <= w_arith & r_carry;
               r_zero      <= (r_shift == '0);
`ifdef OVERFLOW_EN
               r_overflow  <= w_arith & r_ovf_msb;
`endif
               r_state     <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
         r_busy <= (r_state == ST_RUN) || (r_state == ST_DONE);
         r_done <= (r_state == ST_DONE);
      end
   end

   assign busy      = r_busy;
   assign done      = r_done;
   assign result    = r_shift;
   assign carry_out = r_carry_out;
   assign zero      = r_zero;
`ifdef OVERFLOW_EN
   assign overflow  = r_overflow;
`endif

endmodule

// File: tb/tb_serial_alu_ctrl.sv
// Directed vector bench for serial_alu_ctrl: table of operations plus start-spam and mid-run reset sequences.
// Define OVERFLOW_EN to also check the overflow output.

module tb_serial_alu_ctrl;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [1:0]   op = 2'b00;
   logic [W-1:0] a = '0, b = '0;
   logic         busy, done, carry_out, zero, overflow;
   logic [W-1:0] result;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   serial_alu_ctrl #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .op        (op),
      .a         (a),
      .b         (b),
      .busy      (busy),
      .done      (done),
      .result    (result),
      .carry_out (carry_out),
      .zero      (zero)
`ifdef OVERFLOW_EN
      ,
      .overflow  (overflow)
`endif
   );

`ifndef OVERFLOW_EN
   assign overflow = 1'b0;
`endif

   typedef struct {
      logic [1:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] res;
      logic         cy;
      logic         z;
      logic         ovf;
   } vec_t;

   vec_t vecs[11];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Runs one operation; when hold is set, start stays high with random operands through RUN/DONE.
   task automatic run_op(input logic [1:0] o, input logic [W-1:0] va, input logic [W-1:0] vb,
                         input bit hold,
                         output logic [W-1:0] res, output logic cy, output logic z, output logic ovf,
                         output int done_at, output int done_cnt, output int busy_cnt);
      done_at = -1; done_cnt = 0; busy_cnt = 0;
      res = 'x; cy = 1'bx; z = 1'bx; ovf = 1'bx;
      @(negedge clk);
      op = o; a = va; b = vb; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = hold;
      op = 2'($urandom); a = W'($urandom); b = W'($urandom);
      for (int k = 1; k <= W + 4; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (busy) busy_cnt++;
         if (done) begin
            done_cnt++;
            if (done_at < 0) begin
               done_at = k;
               res = result; cy = carry_out; z = zero; ovf = overflow;
            end
         end
         start = hold && (k <= W);
         a = W'($urandom); b = W'($urandom);
      end
      start = 1'b0;
   endtask

   initial begin
      logic [W-1:0] res;
      logic         cy, z, ovf;
      int           done_at, done_cnt, busy_cnt;

      //            op     a      b      res    cy    z     ovf
      vecs[0]  = '{2'b10, 8'h0F, 8'h01, 8'h10, 1'b0, 1'b0, 1'b0};
      vecs[1]  = '{2'b10, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0};
      vecs[2]  = '{2'b11, 8'h07, 8'h05, 8'h02, 1'b1, 1'b0, 1'b0};
      vecs[3]  = '{2'b11, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0, 1'b0};
      vecs[4]  = '{2'b00, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0};
      vecs[5]  = '{2'b01, 8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b0, 1'b0};
      vecs[6]  = '{2'b00, 8'h0F, 8'hF0, 8'h00, 1'b0, 1'b1, 1'b0};
      vecs[7]  = '{2'b10, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1};
      vecs[8]  = '{2'b11, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b0, 1'b1};
      vecs[9]  = '{2'b10, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0};
      vecs[10] = '{2'b11, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0};

      repeat (3) @(negedge clk);
      check("reset busy", 32'(busy), 0);
      check("reset done", 32'(done), 0);
      check("reset result", 32'(result), 0);
      check("reset carry_out", 32'(carry_out), 0);
      check("reset zero", 32'(zero), 0);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, res, cy, z, ovf, done_at, done_cnt, busy_cnt);
         check($sformatf("v%0d done latency", i), 32'(done_at), W + 1);
         check($sformatf("v%0d done count", i), 32'(done_cnt), 1);
         check($sformatf("v%0d busy cycles", i), 32'(busy_cnt), W + 1);
         check($sformatf("v%0d result", i), 32'(res), 32'(vecs[i].res));
         check($sformatf("v%0d carry_out", i), 32'(cy), 32'(vecs[i].cy));
         check($sformatf("v%0d zero", i), 32'(z), 32'(vecs[i].z));
`ifdef OVERFLOW_EN
         check($sformatf("v%0d overflow", i), 32'(ovf), 32'(vecs[i].ovf));
`endif
      end

      // Held result must survive the idle cycles after DONE.
      repeat (3) @(negedge clk);
      check("hold result", 32'(result), 32'h00);
      check("hold carry_out", 32'(carry_out), 1);
      check("hold zero", 32'(zero), 1);

      // start spammed with new operands through RUN and DONE: only the first request counts.
      run_op(2'b10, 8'h01, 8'h01, 1'b1, res, cy, z, ovf, done_at, done_cnt, busy_cnt);
      check("spam done latency", 32'(done_at), W + 1);
      check("spam done count", 32'(done_cnt), 1);
      check("spam busy cycles", 32'(busy_cnt), W + 1);
      check("spam result", 32'(res), 32'h02);
      check("spam idle busy", 32'(busy), 0);

      // Reset asserted for one cycle while bit 3 is in flight.
      @(negedge clk);
      op = 2'b10; a = 8'hAA; b = 8'h55; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rst busy", 32'(busy), 0);
      check("rst done", 32'(done), 0);
      check("rst result", 32'(result), 0);
      @(negedge clk);
      rst_n = 1'b1;
      begin
         int n_done = 0;
         int n_busy = 0;
         for (int k = 0; k < W + 4; k++) begin
            @(negedge clk);
            if (done) n_done++;
            if (busy) n_busy++;
         end
         check("post-rst no done", 32'(n_done), 0);
         check("post-rst no busy", 32'(n_busy), 0);
      end
      run_op(2'b10, 8'h02, 8'h03, 1'b0, res, cy, z, ovf, done_at, done_cnt, busy_cnt);
      check("post-rst done latency", 32'(done_at), W + 1);
      check("post-rst done count", 32'(done_cnt), 1);
      check("post-rst result", 32'(res), 32'h05);
      check("post-rst carry_out", 32'(cy), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
